// File: rtl/solution_capture_fifo.sv
// solution_capture_fifo: captures the corrected winning nonce from block_solver into a
// small FIFO for the SPI register file, and counts hash attempts.
//
// Optional feature macro: SOLUTION_CAPTURE_TIMESTAMP_EN
//   defined   -> each entry also stores a free-running 32-bit cycle stamp
//   undefined -> no stamp storage, rd_timestamp tied to 0
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   state_in[2:0]     solver state; bit 2 = solution found (level)
//   nonce_in[31:0]    solver current nonce
//   clear_job         flush pulse on new job (priority over capture/pop)
//   pop               discard head entry
//   rd_valid          FIFO not empty
//   rd_nonce          head entry nonce (nonce_in - NONCE_OFFSET at capture)
//   rd_timestamp      head entry cycle stamp (0 when the feature is off)
//   count             entries held
//   overflow          sticky: a capture was dropped while full
//   hash_count        saturating count of nonce changes since last clear
//   irq               rd_valid delayed one cycle
module solution_capture_fifo #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned NONCE_OFFSET = 0,
  parameter int unsigned HASH_CNT_W   = 40
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2:0]                state_in,
  input  logic [31:0]               nonce_in,
  input  logic                      clear_job,
  input  logic                      pop,
  output logic                      rd_valid,
  output logic [31:0]               rd_nonce,
  output logic [31:0]               rd_timestamp,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [HASH_CNT_W-1:0]     hash_count,
  output logic                      irq
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr, rdPtr, wrPtrNext, rdPtrNext;
  logic [CNT_W-1:0]  countNext;
  logic              overflowNext;
  logic [HASH_CNT_W-1:0] hashNext;
  logic              flagPrev;
  logic [31:0]       noncePrev;
  logic              capture, isEmpty, isFull, pushOk, popOk, nonceChanged, headBypass;
  logic [31:0]       capNonce, headNonce;

  // Only the solution flag is consumed from the solver state bus.
  logic unusedStateBits;
  assign unusedStateBits = ^state_in[1:0];

  assign capture      = state_in[2] & ~flagPrev;
  assign isEmpty      = (count == '0);
  assign isFull       = (count == CNT_W'(DEPTH));
  // A pop while full frees the slot the simultaneous capture lands in.
  assign pushOk       = capture & ~clear_job & (~isFull | pop);
  assign popOk        = pop & ~clear_job & ~isEmpty;
  assign capNonce     = nonce_in - 32'(NONCE_OFFSET);
  assign nonceChanged = (nonce_in != noncePrev);

  // Next-state for pointers, occupancy, sticky flag and hash counter.
  always_comb begin
    wrPtrNext    = wrPtr;
    rdPtrNext    = rdPtr;
    countNext    = count;
    overflowNext = overflow;
    hashNext     = hash_count;
    if (clear_job) begin
      wrPtrNext    = '0;
      rdPtrNext    = '0;
      countNext    = '0;
      overflowNext = 1'b0;
      hashNext     = '0;
    end else begin
      if (pushOk) wrPtrNext = wrPtr + PTR_W'(1);
      if (popOk)  rdPtrNext = rdPtr + PTR_W'(1);
      countNext = count + CNT_W'(pushOk) - CNT_W'(popOk);
      if (capture && isFull && !pop) overflowNext = 1'b1;
      if (nonceChanged && (hash_count != '1)) hashNext = hash_count + HASH_CNT_W'(1);
    end
  end

  // New head is the entry being written this cycle when it lands at the next read slot.
  assign headBypass = pushOk && (wrPtr == rdPtrNext);
  assign headNonce  = headBypass ? capNonce : mem[rdPtrNext];

  // Storage array, no reset needed: entries are only read once written.
  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr] <= capNonce;
  end

  // Control state and registered head outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flagPrev   <= 1'b0;
      noncePrev  <= '0;
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      hash_count <= '0;
      rd_valid   <= 1'b0;
      rd_nonce   <= '0;
      irq        <= 1'b0;
    end else begin
      flagPrev   <= state_in[2];
      noncePrev  <= nonce_in;
      wrPtr      <= wrPtrNext;
      rdPtr      <= rdPtrNext;
      count      <= countNext;
      overflow   <= overflowNext;
      hash_count <= hashNext;
      rd_valid   <= (countNext != '0);
      if (countNext != '0) rd_nonce <= headNonce;
      irq        <= rd_valid;
    end
  end

`ifdef SOLUTION_CAPTURE_TIMESTAMP_EN
  logic [31:0] tsMem [DEPTH];
  logic [31:0] cycleCnt, headTs;

  assign headTs = headBypass ? cycleCnt : tsMem[rdPtrNext];

  always_ff @(posedge clk) begin
    if (pushOk) tsMem[wrPtr] <= cycleCnt;
  end

  // Free-running stamp; only rst_n clears it so stamps stay comparable across jobs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycleCnt     <= '0;
      rd_timestamp <= '0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      if (!clear_job && (countNext != '0)) rd_timestamp <= headTs;
    end
  end
`else
  assign rd_timestamp = '0;
`endif

endmodule

// File: tb/tb_solution_capture_fifo.sv
// Self-checking bench for solution_capture_fifo: a queue-based reference model tracks
// expected FIFO contents; a negedge monitor compares every output every cycle, and
// directed steps add explicit checks for the headline scenarios.
module tb_solution_capture_fifo;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  stateIn = '0;
  logic [31:0] nonceIn = '0;
  logic        clearJob = 1'b0;
  logic        popIn = 1'b0;

  logic        rdValid, sRdValid;
  logic [31:0] rdNonce, sRdNonce, rdTs, sRdTs;
  logic [2:0]  cnt, sCnt;
  logic        ovf, sOvf, irqO, sIrq;
  logic [39:0] hashCnt;
  logic [3:0]  sHash;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  solution_capture_fifo #(.DEPTH(DEPTH), .NONCE_OFFSET(5), .HASH_CNT_W(40)) dut (
    .clk(clk), .rst_n(rst_n), .state_in(stateIn), .nonce_in(nonceIn),
    .clear_job(clearJob), .pop(popIn), .rd_valid(rdValid), .rd_nonce(rdNonce),
    .rd_timestamp(rdTs), .count(cnt), .overflow(ovf), .hash_count(hashCnt), .irq(irqO));

  solution_capture_fifo #(.DEPTH(DEPTH), .NONCE_OFFSET(3), .HASH_CNT_W(4)) dutSmall (
    .clk(clk), .rst_n(rst_n), .state_in(stateIn), .nonce_in(nonceIn),
    .clear_job(clearJob), .pop(popIn), .rd_valid(sRdValid), .rd_nonce(sRdNonce),
    .rd_timestamp(sRdTs), .count(sCnt), .overflow(sOvf), .hash_count(sHash), .irq(sIrq));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of {nonce corrected by 5, stamp}; small instance adds 2.
  typedef struct packed { logic [31:0] n; logic [31:0] ts; } entry_t;
  entry_t      q[$];
  entry_t      e;
  bit          mFlagPrev, mValid, mIrq, mOvf, cap, wasFull;
  logic [31:0] mNoncePrev, mCyc, mHeadN, mHeadS, mHeadTs;
  longint unsigned mHash, mHashSmall;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      mFlagPrev = 0; mValid = 0; mIrq = 0; mOvf = 0;
      mNoncePrev = 0; mCyc = 0; mHeadN = 0; mHeadS = 0; mHeadTs = 0;
      mHash = 0; mHashSmall = 0;
    end else begin
      cap = stateIn[2] && !mFlagPrev;
      if (clearJob) begin
        q.delete();
        mOvf = 0; mHash = 0; mHashSmall = 0;
      end else begin
        wasFull = (q.size() == DEPTH);
        e.n = nonceIn - 32'd5;
        e.ts = mCyc;
        if (popIn && q.size() != 0) void'(q.pop_front());
        if (cap) begin
          if (wasFull && !popIn) mOvf = 1;
          else q.push_back(e);
        end
        if (nonceIn != mNoncePrev) begin
          if (mHash < 64'hFF_FFFF_FFFF) mHash++;
          if (mHashSmall < 15) mHashSmall++;
        end
      end
      mIrq = mValid;
      mValid = (q.size() != 0);
      if (mValid) begin
        mHeadN = q[0].n;
        mHeadS = q[0].n + 32'd2;
        mHeadTs = q[0].ts;
      end
      mFlagPrev = stateIn[2];
      mNoncePrev = nonceIn;
      mCyc++;
    end
  end

  function automatic logic [31:0] expTs();
`ifdef SOLUTION_CAPTURE_TIMESTAMP_EN
    return mHeadTs;
`else
    return 32'd0;
`endif
  endfunction

  // Monitor: compare every output against the model away from the active edge.
  always @(negedge clk) begin
    chk("rd_valid", 64'(rdValid), 64'(mValid));
    chk("count", 64'(cnt), 64'(q.size()));
    chk("overflow", 64'(ovf), 64'(mOvf));
    chk("hash_count", 64'(hashCnt), mHash);
    chk("irq", 64'(irqO), 64'(mIrq));
    chk("rd_nonce", 64'(rdNonce), 64'(mHeadN));
    chk("rd_timestamp", 64'(rdTs), 64'(expTs()));
    chk("s_rd_valid", 64'(sRdValid), 64'(mValid));
    chk("s_count", 64'(sCnt), 64'(q.size()));
    chk("s_overflow", 64'(sOvf), 64'(mOvf));
    chk("s_hash_count", 64'(sHash), mHashSmall);
    chk("s_irq", 64'(sIrq), 64'(mIrq));
    chk("s_rd_nonce", 64'(sRdNonce), 64'(mHeadS));
    chk("s_rd_timestamp", 64'(sRdTs), 64'(expTs()));
  end

  // One clock: inputs set before the call are sampled at the posedge; returns just after negedge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic capture(input logic [31:0] n);
    nonceIn = n; stateIn = 3'b100; step();
    stateIn = 3'b000; step();
  endtask

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("reset rd_valid", 64'(rdValid), 64'd0);
    chk("reset count", 64'(cnt), 64'd0);
    chk("reset overflow", 64'(ovf), 64'd0);
    chk("reset hash", 64'(hashCnt), 64'd0);
    chk("reset rd_nonce", 64'(rdNonce), 64'd0);

    // Capture with latency correction; holding the flag does not recapture.
    nonceIn = 32'h0000_1000; stateIn = 3'b100; step();
    chk("t1 valid", 64'(rdValid), 64'd1);
    chk("t1 count", 64'(cnt), 64'd1);
    chk("t1 small nonce", 64'(sRdNonce), 64'h0000_0FFD);
    chk("t1 nonce", 64'(rdNonce), 64'h0000_0FFB);
    repeat (10) step();
    chk("t1 held count", 64'(cnt), 64'd1);

    // Pop to empty, wrap-around correction, pop while empty.
    stateIn = 3'b000; popIn = 1'b1; step(); popIn = 1'b0;
    chk("t2 empty", 64'(cnt), 64'd0);
    nonceIn = 32'd2; stateIn = 3'b100; step(); stateIn = 3'b000;
    chk("t2 wrap nonce", 64'(rdNonce), 64'hFFFF_FFFD);
    popIn = 1'b1; step(); popIn = 1'b0;
    chk("t2 popped valid", 64'(rdValid), 64'd0);
    chk("t2 popped count", 64'(cnt), 64'd0);
    popIn = 1'b1; step(); popIn = 1'b0;
    chk("t2 underflow count", 64'(cnt), 64'd0);

    // Fill past full, then capture+pop while full, then drain in order.
    for (int i = 0; i < 5; i++) capture(32'h100 + 32'(i));
    chk("t3 full count", 64'(cnt), 64'd4);
    chk("t3 overflow", 64'(ovf), 64'd1);
    chk("t3 head", 64'(rdNonce), 64'(32'h100 - 32'd5));
    nonceIn = 32'h200; stateIn = 3'b100; popIn = 1'b1; step();
    stateIn = 3'b000; popIn = 1'b0;
    chk("t3 full push+pop count", 64'(cnt), 64'd4);
    begin
      logic [31:0] order [4];
      order[0] = 32'h101; order[1] = 32'h102; order[2] = 32'h103; order[3] = 32'h200;
      for (int i = 0; i < 4; i++) begin
        chk("t3 order", 64'(rdNonce), 64'(order[i] - 32'd5));
        popIn = 1'b1; step(); popIn = 1'b0;
      end
    end
    chk("t3 drained", 64'(cnt), 64'd0);

    // Hash counting and saturation of the narrow instance.
    clearJob = 1'b1; step(); clearJob = 1'b0;
    chk("t4 hash cleared", 64'(hashCnt), 64'd0);
    for (int i = 0; i < 100; i++) begin nonceIn = nonceIn + 32'd1; step(); end
    repeat (20) step();
    chk("t4 hash 100", 64'(hashCnt), 64'd100);
    chk("t4 hash saturate", 64'(sHash), 64'd15);

    // clear_job beats a simultaneous capture and pop.
    for (int i = 0; i < 5; i++) capture(32'h300 + 32'(i));
    popIn = 1'b1; step(); popIn = 1'b0;
    chk("t5 three entries", 64'(cnt), 64'd3);
    chk("t5 overflow set", 64'(ovf), 64'd1);
    nonceIn = 32'h400; stateIn = 3'b100; popIn = 1'b1; clearJob = 1'b1; step();
    popIn = 1'b0; clearJob = 1'b0;
    chk("t5 clear count", 64'(cnt), 64'd0);
    chk("t5 clear overflow", 64'(ovf), 64'd0);
    chk("t5 clear hash", 64'(hashCnt), 64'd0);
    chk("t5 clear valid", 64'(rdValid), 64'd0);
    step(); stateIn = 3'b000;
    chk("t5 capture dropped", 64'(cnt), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      stateIn[2]   = ($urandom_range(0, 3) == 0);
      stateIn[1:0] = 2'($urandom);
      popIn        = ($urandom_range(0, 2) == 0);
      clearJob     = ($urandom_range(0, 60) == 0);
      case ($urandom_range(0, 3))
        0, 1: nonceIn = nonceIn + 32'd1;
        2:    nonceIn = nonceIn;
        default: nonceIn = $urandom;
      endcase
      step();
      // Mid-stream asynchronous reset, applied between clock edges.
      if (i == 1500) begin
        stateIn = 3'b000; popIn = 1'b0; clearJob = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("areset rd_valid", 64'(rdValid), 64'd0);
        chk("areset count", 64'(cnt), 64'd0);
        chk("areset overflow", 64'(ovf), 64'd0);
        chk("areset hash", 64'(hashCnt), 64'd0);
        chk("areset irq", 64'(irqO), 64'd0);
        chk("areset rd_nonce", 64'(rdNonce), 64'd0);
        chk("areset rd_timestamp", 64'(rdTs), 64'd0);
        step(); step();
        rst_n = 1'b1;
        step();
      end
    end

    stateIn = 3'b000; popIn = 1'b0; clearJob = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
